// File: rtl/velocity_cell_reader_if.sv
// rtl/velocity_cell_reader_if.sv - velocity RAM read port and particle stream bundle
interface velocity_cell_reader_if #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_rden;
    logic                  mem_wren;
    logic [DATA_WIDTH-1:0] mem_q;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_index;
    logic                  out_last;

    modport master (
        output mem_address,
        output mem_rden,
        output mem_wren,
        input  mem_q,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_index,
        output out_last
    );

    modport slave (
        input  mem_address,
        input  mem_rden,
        input  mem_wren,
        output mem_q,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_index,
        input  out_last
    );
endinterface

// File: rtl/velocity_cell_reader.sv
// rtl/velocity_cell_reader.sv - reads a cell's particle count then streams its velocity words
module velocity_cell_reader #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic                  count_err,
    velocity_cell_reader_if.master bus
);

    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_CNT,
        ST_WAIT_CNT,
        ST_STREAM,
        ST_FIN
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] next_rd_addr;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic                  inflight;
    logic [ADDR_WIDTH-1:0] inflight_addr;

    // Two-entry skid FIFO holding returned words tagged with their address.
    logic [DATA_WIDTH-1:0] fifo_data  [2];
    logic [ADDR_WIDTH-1:0] fifo_index [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_count;

    logic [ADDR_WIDTH-1:0] raw_count;
    logic [ADDR_WIDTH-1:0] clamped_count;
    logic                  out_valid_int;
    logic                  out_last_int;
    logic                  pop;
    logic [2:0]            occ_next;
    logic                  issue;

    // Count clamping from the word returned for address 0.
    always_comb begin
        raw_count     = bus.mem_q[ADDR_WIDTH-1:0];
        clamped_count = (raw_count > MAX_COUNT) ? MAX_COUNT : raw_count;
    end

    // Stream head, handshake and read-issue decision; a read is issued only
    // when the FIFO is guaranteed to have room for it when it returns.
    always_comb begin
        out_valid_int = (fifo_count != 2'd0);
        out_last_int  = out_valid_int && (fifo_index[rd_ptr] == particle_count);
        pop           = out_valid_int && bus.out_ready;
        occ_next      = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
        issue         = (state == ST_STREAM) && (next_rd_addr <= particle_count)
                        && (occ_next < 3'd2);
    end

    // RAM port drive; the address holds its last value when no read is issued.
    always_comb begin
        bus.mem_wren = 1'b0;
        bus.mem_rden = (state == ST_RD_CNT) || issue;
        if (state == ST_RD_CNT) begin
            bus.mem_address = '0;
        end else if (issue) begin
            bus.mem_address = next_rd_addr;
        end else begin
            bus.mem_address = addr_hold;
        end
    end

    // Stream outputs come straight from the FIFO head.
    always_comb begin
        bus.out_valid = out_valid_int;
        bus.out_data  = fifo_data[rd_ptr];
        bus.out_index = fifo_index[rd_ptr];
        bus.out_last  = out_last_int;
    end

    // Control FSM with registered busy/done/count/err.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            particle_count <= '0;
            count_err      <= 1'b0;
            next_rd_addr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= ST_RD_CNT;
                        busy      <= 1'b1;
                        count_err <= 1'b0;
                    end
                end
                ST_RD_CNT: begin
                    state <= ST_WAIT_CNT;
                end
                ST_WAIT_CNT: begin
                    particle_count <= clamped_count;
                    if (raw_count > MAX_COUNT) begin
                        count_err <= 1'b1;
                    end
                    if (clamped_count == '0) begin
                        state <= ST_FIN;
                        done  <= 1'b1;
                    end else begin
                        state        <= ST_STREAM;
                        next_rd_addr <= ONE;
                    end
                end
                ST_STREAM: begin
                    if (issue) begin
                        next_rd_addr <= next_rd_addr + ONE;
                    end
                    if (pop && out_last_int) begin
                        state <= ST_FIN;
                        done  <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Address hold, in-flight tracking and FIFO push/pop.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            addr_hold     <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            fifo_count    <= 2'd0;
            fifo_data[0]  <= '0;
            fifo_data[1]  <= '0;
            fifo_index[0] <= '0;
            fifo_index[1] <= '0;
        end else begin
            addr_hold <= bus.mem_address;
            inflight  <= issue;
            if (issue) begin
                inflight_addr <= next_rd_addr;
            end
            if (inflight) begin
                fifo_data[wr_ptr]  <= bus.mem_q;
                fifo_index[wr_ptr] <= inflight_addr;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= occ_next[1:0];
        end
    end

endmodule

// File: tb/tb_velocity_cell_reader.sv
// tb/tb_velocity_cell_reader.sv - self-checking bench for velocity_cell_reader
module tb_velocity_cell_reader;

    localparam int DW   = 96;
    localparam int AW   = 8;
    localparam int PNUM = 220;

    localparam logic [DW-1:0] CNT3_WORD = 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FF03;
    localparam logic [DW-1:0] WORD_A    = 96'h0000_0011_0000_0022_0000_0033;
    localparam logic [DW-1:0] WORD_B    = 96'h1234_5678_9ABC_DEF0_0F0F_0F0F;
    localparam logic [DW-1:0] WORD_C    = 96'hCAFE_F00D_DEAD_BEEF_8000_0001;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [AW-1:0] particle_count;
    logic          count_err;

    velocity_cell_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    velocity_cell_reader #(
        .DATA_WIDTH(DW), .PARTICLE_NUM(PNUM), .ADDR_WIDTH(AW)
    ) dut (
        .clock(clock), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .particle_count(particle_count), .count_err(count_err), .bus(bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // RAM model: 1-cycle read latency
    logic [DW-1:0] mem [0:255];
    always @(posedge clock) if (bus.mem_rden) bus.mem_q <= mem[bus.mem_address];
    initial bus.mem_q = '0;

    // downstream ready: always 1, or the repeating pattern 1,0,0,1,0,1
    bit       ready_mode = 1'b0;
    bit [5:0] rpat = 6'b101001;
    int       rpos = 0;
    initial bus.out_ready = 1'b1;
    always @(posedge clock) begin
        #1;
        if (ready_mode) begin
            bus.out_ready = rpat[rpos];
            rpos = (rpos + 1) % 6;
        end else begin
            bus.out_ready = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // behavioural model state
    bit            model_busy    = 1'b0;
    bit            zero_expected = 1'b1;
    int            acc           = 0;
    int            off           = 0;
    int            exp_n         = 0;
    bit            exp_err       = 1'b0;
    int            exp_done_cyc  = -1;
    int            issued        = 0;
    int            delivered     = 0;
    logic [DW-1:0] exp_q [$];
    bit            prev_stall    = 1'b0;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_idx;
    bit            busy_before;
    int            raw;

    // logs for per-test literal expectations
    logic [DW-1:0] got_data [$];
    int            got_idx  [$];
    int            rden_off [$];
    int            rden_addr[$];
    int            first_valid_off = -1;
    int            done_off        = -1;
    int            done_seen       = 0;
    int            dut_done_cnt    = 0;

    // compare process: every cycle, checked against the model
    always @(negedge clock) begin
        if (zero_expected) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_particle_count", particle_count, 0);
            chk("rst_count_err", count_err, 0);
            chk("rst_mem_address", bus.mem_address, 0);
            chk("rst_mem_rden", bus.mem_rden, 0);
            chk("rst_mem_wren", bus.mem_wren, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_data", bus.out_data, 0);
            chk("rst_out_index", bus.out_index, 0);
            chk("rst_out_last", bus.out_last, 0);
            prev_stall = 1'b0;
        end else begin
            off = cyc - acc;
            chk("busy", busy, model_busy);
            chk("done", done, model_busy && (cyc == exp_done_cyc));
            chk("mem_wren", bus.mem_wren, 0);
            if (model_busy && off == 1) begin
                chk("count_rden", bus.mem_rden, 1);
                chk("count_addr", bus.mem_address, 0);
                chk("err_cleared", count_err, 0);
            end
            if (model_busy && off >= 3) begin
                chk("particle_count", particle_count, exp_n);
                chk("count_err", count_err, exp_err);
            end
            if (model_busy && off == 3 && exp_n > 0) chk("first_issue", bus.mem_rden, 1);
            if (bus.mem_rden && !(model_busy && off == 1)) begin
                chk("issue_window", model_busy && off >= 3, 1);
                chk("issue_addr", bus.mem_address, issued + 1);
                chk("issue_bound", int'(bus.mem_address) <= exp_n, 1);
                issued++;
            end
            if (bus.mem_rden) begin
                rden_off.push_back(off);
                rden_addr.push_back(int'(bus.mem_address));
            end
            if (model_busy && off == 5 && exp_n > 0) chk("first_valid", bus.out_valid, 1);
            if (prev_stall) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", bus.out_data, prev_data);
                chk("stall_index", bus.out_index, prev_idx);
            end
            if (bus.out_valid) begin
                if (first_valid_off < 0) first_valid_off = off;
                chk("valid_in_read", model_busy && exp_q.size() > 0, 1);
                chk("out_index", bus.out_index, delivered + 1);
                if (exp_q.size() > 0) chk("out_data", bus.out_data, exp_q[0]);
                chk("out_last", bus.out_last, (delivered + 1) == exp_n);
            end else begin
                chk("last_no_valid", bus.out_last, 0);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_idx   = bus.out_index;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                delivered++;
                got_data.push_back(bus.out_data);
                got_idx.push_back(int'(bus.out_index));
                if (delivered == exp_n) exp_done_cyc = cyc + 1;
            end
            chk("outstanding", (issued - delivered) <= 2, 1);
            if (done) begin
                dut_done_cnt++;
                done_seen++;
                done_off = off;
            end
            busy_before = model_busy;
            if (model_busy && cyc == exp_done_cyc) model_busy = 1'b0;
            if (rst_n && start && !busy_before) begin
                model_busy = 1'b1;
                acc        = cyc;
                raw        = int'(mem[0][AW-1:0]);
                exp_n      = (raw > PNUM - 1) ? PNUM - 1 : raw;
                exp_err    = (raw > PNUM - 1);
                exp_done_cyc = (exp_n == 0) ? cyc + 3 : -1;
                issued     = 0;
                delivered  = 0;
                exp_q.delete();
                for (int i = 1; i <= exp_n; i++) exp_q.push_back(mem[i]);
                got_data.delete();
                got_idx.delete();
                rden_off.delete();
                rden_addr.delete();
                first_valid_off = -1;
                done_off        = -1;
                done_seen       = 0;
            end
        end
        if (!rst_n) begin
            model_busy    = 1'b0;
            exp_q.delete();
            issued        = 0;
            delivered     = 0;
            prev_stall    = 1'b0;
            zero_expected = 1'b1;
        end else begin
            zero_expected = 1'b0;
        end
    end

    task automatic fill_cell(input logic [DW-1:0] cnt_word, input int seed);
        mem[0] = cnt_word;
        for (int i = 1; i < 256; i++)
            mem[i] = {32'(seed), 32'(i), 32'hA5A5_0000 ^ 32'(i * (seed + 3))};
    endtask

    task automatic pulse_start();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int d0;
        int k;
        d0 = dut_done_cnt;
        for (k = 0; k < limit && dut_done_cnt == d0; k++) begin
            @(negedge clock); #1;
        end
        chk(name, dut_done_cnt != d0, 1);
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic wait_words(input string name, input int n, input int limit);
        int k;
        for (k = 0; k < limit && got_idx.size() < n; k++) begin
            @(posedge clock); #1;
        end
        chk(name, got_idx.size() >= n, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clock);
        #1 rst_n = 1'b1;

        // count 3 (upper bits of the count word are ignored), ready always 1
        fill_cell(CNT3_WORD, 1);
        mem[1] = WORD_A; mem[2] = WORD_B; mem[3] = WORD_C;
        pulse_start();
        wait_done("t1_timeout", 200);
        chk("t1_first_valid_off", first_valid_off, 5);
        chk("t1_done_off", done_off, 8);
        chk("t1_words", got_data.size(), 3);
        if (got_data.size() == 3) begin
            chk("t1_data_A", got_data[0], WORD_A);
            chk("t1_data_C", got_data[2], WORD_C);
            chk("t1_idx_C", got_idx[2], 3);
        end
        chk("t1_rden_n", rden_off.size(), 4);
        if (rden_off.size() == 4) begin
            chk("t1_rden_off0", rden_off[0], 1);
            chk("t1_rden_off1", rden_off[1], 3);
            chk("t1_rden_off3", rden_off[3], 5);
            chk("t1_rden_addr3", rden_addr[3], 3);
        end

        // count 0
        fill_cell(96'd0, 2);
        pulse_start();
        wait_done("t2_timeout", 200);
        chk("t2_done_off", done_off, 3);
        chk("t2_words", got_data.size(), 0);
        chk("t2_rden_n", rden_off.size(), 1);
        chk("t2_particle_count", particle_count, 0);

        // count 5 under backpressure
        fill_cell(96'd5, 3);
        ready_mode = 1'b1;
        pulse_start();
        wait_done("t3_timeout", 400);
        ready_mode = 1'b0;
        chk("t3_words", got_idx.size(), 5);
        if (got_idx.size() == 5) chk("t3_idx_last", got_idx[4], 5);
        chk("t3_done_seen", done_seen, 1);

        // raw count 250 clamps to 219
        fill_cell(96'd250, 4);
        pulse_start();
        wait_done("t4_timeout", 1000);
        chk("t4_particle_count", particle_count, 219);
        chk("t4_count_err", count_err, 1);
        chk("t4_words", got_idx.size(), 219);
        if (got_idx.size() == 219) chk("t4_idx_last", got_idx[218], 219);

        // start pulsed during STREAM is ignored; count_err clears on new start
        fill_cell(96'd4, 5);
        pulse_start();
        wait_words("t6_first_word", 1, 100);
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        wait_done("t6_timeout", 200);
        repeat (10) @(posedge clock);
        #1;
        chk("t6_done_seen", done_seen, 1);
        chk("t6_words", got_idx.size(), 4);
        chk("t6_count_err", count_err, 0);
        chk("t6_idle", busy, 0);

        // reset after the 2nd handshake of a count-10 read, then restart
        fill_cell(96'd10, 6);
        pulse_start();
        wait_words("t5_two_words", 2, 100);
        rst_n = 1'b0;
        @(posedge clock); #1 rst_n = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        chk("t5_no_done", done_seen, 0);
        chk("t5_idle", busy, 0);
        pulse_start();
        wait_done("t5_timeout", 200);
        chk("t5_words", got_idx.size(), 10);
        if (got_idx.size() == 10) chk("t5_first_idx", got_idx[0], 1);
        chk("t5_done_seen", done_seen, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/velocity_cell_reader.md
Name: velocity_cell_reader

Overview:
Read-side sequencer for one per-cell velocity memory. Address 0 of that memory holds the cell particle count; addresses 1..N hold {vz, vy, vx}. On a start pulse, the block reads the count, then streams every particle velocity word out on a valid/ready interface. It hides the memory's 1-cycle read latency and absorbs downstream backpressure. It sits between the cell velocity RAM and the motion-update / velocity cache logic.

Parameters:
DATA_WIDTH, 96, width of one velocity word {vz, vy, vx}, 32 bits each
PARTICLE_NUM, 220, memory depth in words; maximum particle count is PARTICLE_NUM-1
ADDR_WIDTH, 8, memory address width

Ports:
clock  in  1  single clock; all logic is on its rising edge
rst_n  in  1  synchronous reset, active-low
start  in  1  1-cycle pulse that begins a cell read; ignored unless the block is idle
busy  out  1  high from the cycle after start is accepted until the cycle that done is high, inclusive
done  out  1  1-cycle pulse at the end of a cell read
particle_count  out  ADDR_WIDTH  count latched from address 0, after clamping
count_err  out  1  sticky; set when the raw count exceeds PARTICLE_NUM-1; cleared on the next accepted start
mem_address  out  ADDR_WIDTH  RAM address
mem_rden  out  1  RAM read enable
mem_wren  out  1  RAM write enable; constant 0
mem_q  in  DATA_WIDTH  RAM read data, valid 1 cycle after the rden cycle
out_valid  out  1  stream data valid
out_ready  in  1  downstream accept
out_data  out  DATA_WIDTH  velocity word {vz, vy, vx}
out_index  out  ADDR_WIDTH  particle address (1..N) of out_data
out_last  out  1  high with the word for particle N

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; FIFO and in-flight flag cleared; all outputs 0. Reset mid-stream aborts immediately, with no done pulse and no further reads.
- States:
  - IDLE: start=1 goes to RD_CNT and clears count_err.
  - RD_CNT (1 cycle): mem_rden=1, mem_address=0.
  - WAIT_CNT (1 cycle): raw = mem_q[ADDR_WIDTH-1:0]. If raw > PARTICLE_NUM-1, clamp to PARTICLE_NUM-1 and set count_err. Latch the result into particle_count.
  - From WAIT_CNT: count==0 goes to FIN; otherwise goes to STREAM with next_rd_addr=1.
  - STREAM: issues reads as described below; goes to FIN on the cycle the out_last word is handshaken.
  - FIN (1 cycle): done=1, then returns to IDLE.
- Read issue in STREAM:
  - Condition: next_rd_addr <= count AND (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready.
  - On issue: mem_rden=1, mem_address=next_rd_addr, next_rd_addr increments, inflight is set for the next cycle.
  - In every other cycle mem_rden=0 and mem_address holds its last value.
- Buffering: a 2-entry FIFO. The returning mem_q is written into the FIFO in the cycle after issue, tagged with its address.
  - out_data, out_index and out_valid come from the FIFO head; out_valid = FIFO non-empty.
  - out_last = out_valid & (out_index == count).
  - A simultaneous push and pop keeps the occupancy unchanged.
  - The FIFO never overflows; no read data is ever dropped.
- Stream rules: once out_valid rises, out_data and out_index stay stable until the handshake. out_ready has no combinational path to mem_rden beyond the pop term above.
- Latency: start sampled at edge T gives RD_CNT in T+1, WAIT_CNT in T+2, first issue in T+3, and first out_valid in T+5. With out_ready held at 1, throughput is 1 word per cycle.
- Timing to done: done is high in the cycle after the last handshake; busy falls in the following cycle. For N=0, done is high in T+3.
- Start while busy is ignored, with no effect on state or count_err.
- Address arithmetic is unsigned ADDR_WIDTH. next_rd_addr never exceeds count+1, so it cannot wrap.

Test Plan:
- Count=3, words A/B/C at addresses 1..3, out_ready=1, start at T -> out_valid cycles T+5..T+7 with index 1,2,3 and data A,B,C; out_last only on C; done at T+8; mem_rden at T+1 (addr 0) and T+3..T+5 (addr 1..3).
- Count=0 -> no mem_rden after addr 0, out_valid never high, done at T+3, particle_count=0.
- Count=5 with out_ready toggling 1,0,0,1,0,1... -> all 5 words delivered in order, none duplicated, out_data stable while stalled, FIFO occupancy never above 2.
- Raw count=250 with PARTICLE_NUM=220 -> particle_count=219, count_err=1, 219 words streamed; count_err clears on the next start.
- rst_n=0 asserted after the 2nd handshake of a count=10 read -> the next cycle has all outputs 0 and no done; a new start then streams from index 1.
- start pulsed again during STREAM -> ignored; exactly one done, sequence unchanged.
